priority_event_encoder: RTL and testbench

Parametrised, registered priority encoder for N event lines. Requests are latched into a pending register, optionally masked, and the winning index is presented on a valid/ready output port until it is consumed. Arbitration is either fixed (index 0 highest) or round-robin. The block sits between raw event/interrupt sources and a single consumer, such as a controller FSM or a bus master.

---
 rtl/prio_pkg.sv | 12 +
 rtl/prio_select.sv | 37 +++
 rtl/priority_event_encoder.sv | 98 +++++++++
 tb/tb_priority_event_encoder.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prio_pkg.sv
// Shared constants for the priority event encoder: arbitration modes and the
// index-width helper used by the top level and the selector.
package prio_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_select.sv
// Rotate-and-find-first: returns the first set request at or above base,
// wrapping at N. The result is then rotated back into absolute index space.
module prio_select
    import prio_pkg::*;
#(
    parameter int  N = 8,
    localparam int W = clog2_min1(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] base,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [N-1:0] rot;
    logic [W:0]   sum;

    // base is always below N, so the doubled vector covers every rotation.
    assign rot = N'({req, req} >> base);

    always_comb begin
        idx = '0;
        any = 1'b0;
        sum = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, base} + (W+1)'(k);
                any = 1'b1;
            end
        end
        if (sum >= (W+1)'(N)) begin
            sum = sum - (W+1)'(N);
        end
        idx = sum[W-1:0];
    end

endmodule

// File: rtl/priority_event_encoder.sv
// Registered priority encoder: latches event requests into a pending set and
// presents one winning index at a time on a valid/ready port.
module priority_event_encoder
    import prio_pkg::*;
#(
    parameter int  N  = 8,
    parameter int  RR = MODE_FIXED,
    localparam int W  = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [N-1:0] inp,
    input  logic [N-1:0] mask,
    input  logic         ready,
    output logic [W-1:0] out,
    output logic         valid,
    output logic [N-1:0] pending,
    output logic         ovf,
    input  logic         ovf_clr
);

    logic [N-1:0] pend_q, pend_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic         valid_q, valid_d;
    logic         ovf_q, ovf_d;

    logic         hs;
    logic         load;
    logic         ovf_set;
    logic [N-1:0] grant_oh;
    logic [N-1:0] cand;
    logic [W-1:0] base;
    logic [W-1:0] sel_idx;
    logic         sel_any;

    assign hs       = valid_q & ready;
    assign load     = ~valid_q | ready;
    assign grant_oh = hs ? ({{(N-1){1'b0}}, 1'b1} << out_q) : '0;
    // Candidates come from the registered pending set only, never from inp.
    assign cand     = pend_q & ~mask & ~grant_oh;
    assign base     = (RR == MODE_RR) ? ptr_q : '0;
    assign ovf_set  = enable & (|(inp & pend_q & ~grant_oh));

    prio_select #(.N(N)) u_select (
        .req  (cand),
        .base (base),
        .idx  (sel_idx),
        .any  (sel_any)
    );

    always_comb begin
        pend_d  = (pend_q & ~grant_oh) | (enable ? inp : '0);
        ovf_d   = ovf_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        out_d   = out_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (hs) begin
            ptr_d = (out_q == W'(N - 1)) ? '0 : out_q + 1'b1;
        end
        if (!enable) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = sel_any;
            if (sel_any) begin
                out_d = sel_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= '0;
            out_q   <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            out_q   <= out_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out     = out_q;
    assign valid   = valid_q;
    assign pending = pend_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_priority_event_encoder.sv
// Bench for priority_event_encoder: fixed N=8, round-robin N=8 and round-robin
// N=6 instances against a behavioural model, with a grant scoreboard.
module tb_priority_event_encoder;

    localparam int NI = 3;
    localparam int NN  [NI] = '{8, 8, 6};
    localparam int RRM [NI] = '{0, 1, 1};

    typedef struct {
        int inst;
        int idx;
    } gr_t;

    logic clk = 1'b0;
    logic rst_n;

    logic [7:0] inp_s  [NI];
    logic [7:0] mask_s [NI];
    logic       rdy_s  [NI];
    logic       en_s   [NI];
    logic       clr_s  [NI];

    logic [2:0] out_w [NI];
    logic       val_w [NI];
    logic       ovf_w [NI];
    logic [7:0] p0, p1;
    logic [5:0] p2;

    logic [7:0] m_pend  [NI];
    int         m_out   [NI];
    bit         m_valid [NI];
    int         m_ptr   [NI];
    bit         m_ovf   [NI];
    logic [7:0] n_pend  [NI];
    int         n_out   [NI];
    bit         n_valid [NI];
    int         n_ptr   [NI];
    bit         n_ovf   [NI];

    gr_t grant_q[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    priority_event_encoder #(.N(8), .RR(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(en_s[0]), .inp(inp_s[0]), .mask(mask_s[0]),
        .ready(rdy_s[0]), .out(out_w[0]), .valid(val_w[0]), .pending(p0),
        .ovf(ovf_w[0]), .ovf_clr(clr_s[0]));

    priority_event_encoder #(.N(8), .RR(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(en_s[1]), .inp(inp_s[1]), .mask(mask_s[1]),
        .ready(rdy_s[1]), .out(out_w[1]), .valid(val_w[1]), .pending(p1),
        .ovf(ovf_w[1]), .ovf_clr(clr_s[1]));

    priority_event_encoder #(.N(6), .RR(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(en_s[2]), .inp(inp_s[2][5:0]), .mask(mask_s[2][5:0]),
        .ready(rdy_s[2]), .out(out_w[2]), .valid(val_w[2]), .pending(p2),
        .ovf(ovf_w[2]), .ovf_clr(clr_s[2]));

    function automatic int get_pend(int i);
        case (i)
            0:       return int'(p0);
            1:       return int'(p1);
            default: return int'({2'b00, p2});
        endcase
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_pend[i]  = 8'h00;
            m_out[i]   = 0;
            m_valid[i] = 1'b0;
            m_ptr[i]   = 0;
            m_ovf[i]   = 1'b0;
        end
    endtask

    // One clock of the reference: the pending set is a bit set, the winner is
    // the first eligible index scanning upward from the pointer modulo n.
    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            int n, base, sel, cand;
            logic [7:0] lim, gbit, s;
            bit hs, found, load;
            n     = NN[i];
            lim   = 8'((1 << n) - 1);
            hs    = m_valid[i] && rdy_s[i];
            gbit  = hs ? 8'(1 << m_out[i]) : 8'h00;
            s     = m_pend[i] & ~mask_s[i] & ~gbit & lim;
            base  = RRM[i] ? m_ptr[i] : 0;
            found = 1'b0;
            sel   = 0;
            for (int k = 0; k < n; k++) begin
                cand = (base + k) % n;
                if (!found && s[cand]) begin
                    found = 1'b1;
                    sel   = cand;
                end
            end
            if (en_s[i] && ((inp_s[i] & m_pend[i] & ~gbit & lim) != 8'h00)) n_ovf[i] = 1'b1;
            else if (clr_s[i]) n_ovf[i] = 1'b0;
            else n_ovf[i] = m_ovf[i];
            n_pend[i] = ((m_pend[i] & ~gbit) | (en_s[i] ? inp_s[i] : 8'h00)) & lim;
            n_ptr[i]  = hs ? (m_out[i] + 1) % n : m_ptr[i];
            if (hs) grant_q.push_back('{inst: i, idx: m_out[i]});
            load = !m_valid[i] || rdy_s[i];
            n_valid[i] = !en_s[i] ? 1'b0 : (load ? found : m_valid[i]);
            n_out[i]   = (en_s[i] && load && found) ? sel : m_out[i];
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            m_pend[i]  = n_pend[i];
            m_out[i]   = n_out[i];
            m_valid[i] = n_valid[i];
            m_ptr[i]   = n_ptr[i];
            m_ovf[i]   = n_ovf[i];
            chk($sformatf("out[%0d]", i), int'(out_w[i]), m_out[i]);
            chk($sformatf("valid[%0d]", i), int'(val_w[i]), int'(m_valid[i]));
            chk($sformatf("pending[%0d]", i), get_pend(i), int'(m_pend[i]));
            chk($sformatf("ovf[%0d]", i), int'(ovf_w[i]), int'(m_ovf[i]));
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            inp_s[i]  = 8'h00;
            mask_s[i] = 8'h00;
            rdy_s[i]  = 1'b1;
            en_s[i]   = 1'b1;
            clr_s[i]  = 1'b0;
        end
    endtask

    // Grant monitor: every DUT handshake must match the next expected grant.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < NI; i++) begin
                    if (val_w[i] && rdy_s[i]) begin
                        if (grant_q.size() == 0) begin
                            chk($sformatf("unexpected_grant[%0d]", i), int'(out_w[i]), -1);
                        end else begin
                            gr_t g;
                            g = grant_q.pop_front();
                            chk("grant_inst", i, g.inst);
                            chk($sformatf("grant_idx[%0d]", i), int'(out_w[i]), g.idx);
                        end
                    end
                end
            end
        end
    end

    initial begin
        idle_all();
        for (int i = 0; i < NI; i++) inp_s[i] = 8'hFF;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_valid", int'(val_w[i]), 0);
            chk("rst_out", int'(out_w[i]), 0);
            chk("rst_pending", get_pend(i), 0);
            chk("rst_ovf", int'(ovf_w[i]), 0);
        end
        rst_n = 1'b1;
        idle_all();
        repeat (3) cyc();
        chk("post_rst_valid", int'(val_w[0]), 0);

        // fixed priority with a late low-index request while stalled
        rdy_s[0] = 1'b0; inp_s[0] = 8'hA0; cyc();
        inp_s[0] = 8'h00; cyc();
        chk("fx_first", int'(out_w[0]), 5);
        chk("fx_first_valid", int'(val_w[0]), 1);
        repeat (3) cyc();
        chk("fx_hold", int'(out_w[0]), 5);
        inp_s[0] = 8'h01; cyc();
        inp_s[0] = 8'h00; cyc();
        chk("fx_stable", int'(out_w[0]), 5);
        chk("fx_pend_a1", get_pend(0), 8'hA1);
        rdy_s[0] = 1'b1; cyc();
        chk("fx_next0", int'(out_w[0]), 0);
        cyc();
        chk("fx_next7", int'(out_w[0]), 7);
        cyc();
        chk("fx_drained_valid", int'(val_w[0]), 0);
        chk("fx_drained_pend", get_pend(0), 0);

        // mask keeps bit 5 pending but ineligible
        rdy_s[0] = 1'b0; inp_s[0] = 8'h60; mask_s[0] = 8'h20; cyc();
        inp_s[0] = 8'h00; cyc();
        chk("mask_out6", int'(out_w[0]), 6);
        rdy_s[0] = 1'b1; cyc();
        chk("mask_pend5", get_pend(0), 8'h20);
        chk("mask_valid0", int'(val_w[0]), 0);
        mask_s[0] = 8'h00; cyc();
        chk("mask_out5", int'(out_w[0]), 5);
        cyc();

        // overflow, set-wins on pending and on ovf_clr
        rdy_s[0] = 1'b0; inp_s[0] = 8'h08; cyc();
        cyc();
        chk("ovf_set", int'(ovf_w[0]), 1);
        inp_s[0] = 8'h00; clr_s[0] = 1'b1; cyc();
        chk("ovf_clr", int'(ovf_w[0]), 0);
        clr_s[0] = 1'b0; rdy_s[0] = 1'b1; inp_s[0] = 8'h08; cyc();
        chk("hs_set_pend", get_pend(0), 8'h08);
        chk("hs_set_ovf", int'(ovf_w[0]), 0);
        rdy_s[0] = 1'b0; clr_s[0] = 1'b1; cyc();
        chk("ovf_set_beats_clr", int'(ovf_w[0]), 1);
        inp_s[0] = 8'h00; cyc();
        clr_s[0] = 1'b0; rdy_s[0] = 1'b1; cyc();

        // enable low drops valid but keeps pending and out
        rdy_s[0] = 1'b0; inp_s[0] = 8'h10; cyc();
        inp_s[0] = 8'h00; cyc();
        chk("en_out4", int'(out_w[0]), 4);
        en_s[0] = 1'b0; cyc();
        chk("en_off_valid", int'(val_w[0]), 0);
        chk("en_off_pend", get_pend(0), 8'h10);
        chk("en_off_out", int'(out_w[0]), 4);
        en_s[0] = 1'b1; rdy_s[0] = 1'b1; cyc();
        chk("en_on_valid", int'(val_w[0]), 1);
        cyc();

        // round-robin sweep, then pointer at 3 with pending {0,5}
        inp_s[1] = 8'hFF; cyc();
        inp_s[1] = 8'h00;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("rr_sweep", int'(out_w[1]), k);
        end
        cyc();
        inp_s[1] = 8'h04; cyc();
        inp_s[1] = 8'h00; cyc(); cyc();
        rdy_s[1] = 1'b0; inp_s[1] = 8'h21; cyc();
        inp_s[1] = 8'h00; cyc();
        chk("rr_ptr3_first", int'(out_w[1]), 5);
        rdy_s[1] = 1'b1; cyc();
        chk("rr_ptr3_second", int'(out_w[1]), 0);
        cyc();

        // N=6 round-robin, pointer wraps 5 -> 0
        inp_s[2] = 8'h3F; cyc();
        inp_s[2] = 8'h00;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("rr6_sweep", int'(out_w[2]), k);
        end
        inp_s[2] = 8'h3F; cyc();
        inp_s[2] = 8'h00; cyc();
        chk("rr6_wrap", int'(out_w[2]), 0);
        repeat (6) cyc();

        // randomized traffic on all instances
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NI; i++) begin
                inp_s[i]  = ($urandom_range(3) == 0) ? 8'($urandom & $urandom) : 8'h00;
                mask_s[i] = ($urandom_range(2) == 0) ? 8'($urandom) : 8'h00;
                rdy_s[i]  = ($urandom_range(3) != 0);
                en_s[i]   = ($urandom_range(9) != 0);
                clr_s[i]  = ($urandom_range(7) == 0);
            end
            cyc();
        end

        // async reset while requests are being presented
        idle_all();
        for (int i = 0; i < NI; i++) begin
            inp_s[i] = 8'hFF;
            rdy_s[i] = 1'b0;
        end
        cyc();
        for (int i = 0; i < NI; i++) inp_s[i] = 8'h00;
        cyc();
        chk("pre_rst_valid", int'(val_w[0]), 1);
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < NI; i++) begin
            chk("async_rst_valid", int'(val_w[i]), 0);
            chk("async_rst_pend", get_pend(i), 0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_all();
        inp_s[0] = 8'h04; cyc();
        inp_s[0] = 8'h00;
        chk("post_rst_lat1", int'(val_w[0]), 0);
        cyc();
        chk("post_rst_lat2", int'(out_w[0]), 2);
        repeat (2) cyc();
        chk("grant_q_empty", grant_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
